// File: rtl/inst_loader_pkg.sv
`default_nettype none
// ============================================================================
// inst_loader_pkg : shared types and constants for the instruction loader
// Rev 1.0
// ============================================================================
package inst_loader_pkg;

    localparam int LEN_INST = 32;

    typedef enum logic [1:0] {
        LDR_IDLE   = 2'd0,
        LDR_HEADER = 2'd1,
        LDR_BODY   = 2'd2,
        LDR_FIN    = 2'd3
    } ldr_state_e;

    // Full 32-bit count against 2**addr_w; widened so the capacity itself fits.
    function automatic logic hdr_oversize(input logic [31:0] n, input int addr_w);
        return {1'b0, n} > (33'd1 << addr_w);
    endfunction

endpackage
`default_nettype wire

// File: rtl/byte_packer.sv
`default_nettype none
// ============================================================================
// byte_packer : big-endian 4-byte to 32-bit word assembler
// Rev 1.0
// ============================================================================
module byte_packer
    import inst_loader_pkg::*;
(
    input  logic                clk,
    input  logic                rstn,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    input  logic                clear,
    output logic [LEN_INST-1:0] word,
    output logic                word_valid
);

    logic [1:0]          cnt_q, cnt_d;
    logic [LEN_INST-1:0] shift_q, shift_d;

    always_comb begin
        cnt_d   = cnt_q;
        shift_d = shift_q;
        if (clear) begin
            cnt_d   = 2'd0;
            shift_d = '0;
        end else if (rx_valid) begin
            cnt_d   = cnt_q + 2'd1;
            shift_d = {shift_q[LEN_INST-9:0], rx_data};
        end
    end

    temp_reg #(.WIDTH(2)) u_cnt (
        .clk(clk), .rstn(rstn), .enable(1'b1), .next(cnt_d), .q(cnt_q)
    );

    temp_reg #(.WIDTH(LEN_INST)) u_shift (
        .clk(clk), .rstn(rstn), .enable(1'b1), .next(shift_d), .q(shift_q)
    );

    // The completed word is presented combinationally on its 4th byte.
    assign word       = {shift_q[LEN_INST-9:0], rx_data};
    assign word_valid = rx_valid & ~clear & (cnt_q == 2'd3);

endmodule
`default_nettype wire

// File: rtl/temp_reg.sv
`default_nettype none
// ============================================================================
// temp_reg : enabled register, asynchronous active-low clear to zero
// Rev 1.0
// ============================================================================
module temp_reg #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             enable,
    input  logic [WIDTH-1:0] next,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q <= '0;
        end else if (enable) begin
            q <= next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/inst_loader.sv
`default_nettype none
// ============================================================================
// inst_loader : boot-time loader streaming UART bytes into instruction memory
// Rev 1.0
// ============================================================================
module inst_loader
    import inst_loader_pkg::*;
#(
    parameter int LEN_MEMISTR_ADDR = 15
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        order,
    output logic                        accepted,
    output logic                        done,
    output logic                        err,
    output logic [LEN_MEMISTR_ADDR:0]   n_inst,
    input  logic [7:0]                  rx_data,
    input  logic                        rx_valid,
    output logic [LEN_MEMISTR_ADDR-1:0] a_inst_mem,
    output logic [LEN_INST-1:0]         d_inst_mem,
    output logic                        we_inst_mem
);

    localparam int AW = LEN_MEMISTR_ADDR;

    logic [1:0]          state_raw_q;
    ldr_state_e          state_q, state_d;
    logic                err_q, err_d;
    logic [AW:0]         wcnt_q, wcnt_d;
    logic [AW:0]         ntot_q, ntot_d;
    logic                we_q, we_d;
    logic [AW-1:0]       addr_q, addr_d;
    logic [LEN_INST-1:0] data_q, data_d;

    logic                busy;
    logic                take;
    logic [LEN_INST-1:0] pk_word;
    logic                pk_valid;

    assign state_q  = ldr_state_e'(state_raw_q);
    assign busy     = (state_q != LDR_IDLE);
    assign accepted = order & ~busy;
    assign take     = rx_valid & ((state_q == LDR_HEADER) | (state_q == LDR_BODY));

    byte_packer u_packer (
        .clk        (clk),
        .rstn       (rstn),
        .rx_data    (rx_data),
        .rx_valid   (take),
        .clear      (accepted),
        .word       (pk_word),
        .word_valid (pk_valid)
    );

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        wcnt_d  = wcnt_q;
        ntot_d  = ntot_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        case (state_q)
            LDR_IDLE: begin
                if (accepted) begin
                    state_d = LDR_HEADER;
                    err_d   = 1'b0;
                    wcnt_d  = '0;
                    ntot_d  = '0;
                end
            end
            LDR_HEADER: begin
                if (pk_valid) begin
                    if (hdr_oversize(pk_word, AW)) begin
                        err_d   = 1'b1;
                        state_d = LDR_FIN;
                    end else if (pk_word == '0) begin
                        state_d = LDR_FIN;
                    end else begin
                        ntot_d  = pk_word[AW:0];
                        state_d = LDR_BODY;
                    end
                end
            end
            LDR_BODY: begin
                // Leave only once the final write is on the bus, so done trails it by one cycle.
                if (we_q && (wcnt_q == ntot_q)) begin
                    state_d = LDR_FIN;
                end else if (pk_valid && (wcnt_q != ntot_q)) begin
                    we_d   = 1'b1;
                    addr_d = wcnt_q[AW-1:0];
                    data_d = pk_word;
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            LDR_FIN: begin
                state_d = LDR_IDLE;
            end
            default: begin
                state_d = LDR_IDLE;
            end
        endcase
    end

    temp_reg #(.WIDTH(2)) u_state (
        .clk(clk), .rstn(rstn), .enable(1'b1), .next(state_d), .q(state_raw_q)
    );

    temp_reg #(.WIDTH(1)) u_err (
        .clk(clk), .rstn(rstn), .enable(1'b1), .next(err_d), .q(err_q)
    );

    temp_reg #(.WIDTH(AW+1)) u_wcnt (
        .clk(clk), .rstn(rstn), .enable(1'b1), .next(wcnt_d), .q(wcnt_q)
    );

    temp_reg #(.WIDTH(AW+1)) u_ntot (
        .clk(clk), .rstn(rstn), .enable(1'b1), .next(ntot_d), .q(ntot_q)
    );

    temp_reg #(.WIDTH(1)) u_we (
        .clk(clk), .rstn(rstn), .enable(1'b1), .next(we_d), .q(we_q)
    );

    temp_reg #(.WIDTH(AW)) u_addr (
        .clk(clk), .rstn(rstn), .enable(1'b1), .next(addr_d), .q(addr_q)
    );

    temp_reg #(.WIDTH(LEN_INST)) u_data (
        .clk(clk), .rstn(rstn), .enable(1'b1), .next(data_d), .q(data_q)
    );

    assign done        = (state_q == LDR_FIN);
    assign err         = err_q;
    assign n_inst      = wcnt_q;
    assign a_inst_mem  = addr_q;
    assign d_inst_mem  = data_q;
    assign we_inst_mem = we_q;

endmodule
`default_nettype wire

// File: tb/tb_inst_loader.sv
`default_nettype none
// ============================================================================
// tb_inst_loader : scoreboard bench for inst_loader (LEN_MEMISTR_ADDR = 4)
// Rev 1.0
// ============================================================================
module tb_inst_loader;

    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          order = 1'b0;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          accepted, done, err, we_inst_mem;
    logic [AW:0]   n_inst;
    logic [AW-1:0] a_inst_mem;
    logic [31:0]   d_inst_mem;

    inst_loader #(.LEN_MEMISTR_ADDR(AW)) dut (
        .clk(clk), .rstn(rstn), .order(order), .accepted(accepted), .done(done),
        .err(err), .n_inst(n_inst), .rx_data(rx_data), .rx_valid(rx_valid),
        .a_inst_mem(a_inst_mem), .d_inst_mem(d_inst_mem), .we_inst_mem(we_inst_mem)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct { int cyc; logic [AW-1:0] a; logic [31:0] d; } wr_t;
    typedef struct { int cyc; logic [AW:0] n; logic e; } dn_t;
    wr_t wq[$];
    dn_t dq[$];
    int  aq[$];
    wr_t ew;
    dn_t ed;
    int  ea;

    function automatic wr_t mk_wr(input int c, input int idx, input logic [31:0] d);
        wr_t t;
        t.cyc = c; t.a = idx[AW-1:0]; t.d = d;
        return t;
    endfunction

    function automatic dn_t mk_dn(input int c, input int n, input logic e);
        dn_t t;
        t.cyc = c; t.n = n[AW:0]; t.e = e;
        return t;
    endfunction

    always @(negedge clk) begin
        if (rstn) begin
            if (we_inst_mem) begin
                checks++;
                if (wq.size() == 0) begin
                    errors++;
                    $display("FAIL write_unexpected cyc=%0d got a=%0d d=%h required no write", cyc, a_inst_mem, d_inst_mem);
                end else begin
                    ew = wq.pop_front();
                    if (ew.cyc != cyc || ew.a !== a_inst_mem || ew.d !== d_inst_mem) begin
                        errors++;
                        $display("FAIL write got cyc=%0d a=%0d d=%h required cyc=%0d a=%0d d=%h",
                                 cyc, a_inst_mem, d_inst_mem, ew.cyc, ew.a, ew.d);
                    end
                end
            end
            if (done) begin
                checks++;
                if (dq.size() == 0) begin
                    errors++;
                    $display("FAIL done_unexpected cyc=%0d got done=1 required 0", cyc);
                end else begin
                    ed = dq.pop_front();
                    if (ed.cyc != cyc || ed.n !== n_inst || ed.e !== err) begin
                        errors++;
                        $display("FAIL done got cyc=%0d n=%0d err=%b required cyc=%0d n=%0d err=%b",
                                 cyc, n_inst, err, ed.cyc, ed.n, ed.e);
                    end
                end
            end
            if (accepted) begin
                checks++;
                if (aq.size() == 0) begin
                    errors++;
                    $display("FAIL accepted_unexpected cyc=%0d got 1 required 0", cyc);
                end else begin
                    ea = aq.pop_front();
                    if (ea != cyc) begin
                        errors++;
                        $display("FAIL accepted got cyc=%0d required cyc=%0d", cyc, ea);
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h required %h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, output int k);
        rx_data  = b;
        rx_valid = 1'b1;
        k        = cyc;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, output int k);
        int kk;
        kk = 0;
        for (int i = 0; i < 4; i++) send(w[31-8*i -: 8], kk);
        k = kk;
    endtask

    task automatic body_word(input int idx, input logic [31:0] w, output int k);
        send_word(w, k);
        wq.push_back(mk_wr(k + 1, idx, w));
    endtask

    task automatic start();
        order = 1'b1;
        aq.push_back(cyc);
        tick();
        order = 1'b0;
    endtask

    function automatic logic [63:0] all_outs();
        return {19'd0, accepted, done, err, n_inst, a_inst_mem, d_inst_mem, we_inst_mem};
    endfunction

    int k;

    initial begin
        k = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", all_outs(), 64'd0);
        rstn = 1'b1;
        tick();

        // Bytes while idle must be dropped
        send_word(32'h0000_0001, k);
        repeat (2) tick();

        // Normal two-word load
        start();
        send_word(32'd2, k);
        body_word(0, 32'hDEAD_BEEF, k);
        body_word(1, 32'h0123_4567, k);
        dq.push_back(mk_dn(k + 2, 2, 1'b0));
        repeat (3) tick();
        chk("normal_n_inst_held", {59'd0, n_inst}, 64'd2);
        chk("normal_addr_held", {60'd0, a_inst_mem}, 64'd1);
        chk("normal_data_held", {32'd0, d_inst_mem}, 64'h0123_4567);

        // Empty program
        start();
        send_word(32'd0, k);
        dq.push_back(mk_dn(k + 1, 0, 1'b0));
        repeat (3) tick();

        // Oversize header: 17 > 16
        start();
        send_word(32'h0000_0011, k);
        dq.push_back(mk_dn(k + 1, 0, 1'b1));
        repeat (2) tick();
        send_word(32'hAABB_CCDD, k);
        tick();
        chk("oversize_err_sticky", {63'd0, err}, 64'd1);
        chk("oversize_n_inst", {59'd0, n_inst}, 64'd0);

        // Full capacity: 16 words
        start();
        chk("err_cleared_on_accept", {63'd0, err}, 64'd0);
        send_word(32'd16, k);
        for (int i = 0; i < 16; i++) body_word(i, 32'hA500_0000 | (i * 32'h0001_0101), k);
        dq.push_back(mk_dn(k + 2, 16, 1'b0));
        repeat (3) tick();
        chk("full_last_addr", {60'd0, a_inst_mem}, 64'd15);
        chk("full_n_inst", {59'd0, n_inst}, 64'd16);

        // Order held high through a whole load
        order = 1'b1;
        aq.push_back(cyc);
        tick();
        send_word(32'd1, k);
        body_word(0, 32'hCAFE_F00D, k);
        dq.push_back(mk_dn(k + 2, 1, 1'b0));
        aq.push_back(k + 3);
        repeat (3) tick();
        order = 1'b0;
        send_word(32'd0, k);
        dq.push_back(mk_dn(k + 1, 0, 1'b0));
        repeat (2) tick();

        // Reset in the middle of the body
        start();
        send_word(32'd3, k);
        body_word(0, 32'h1122_3344, k);
        send(8'h55, k);
        send(8'h66, k);
        @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        chk("async_reset_outputs", all_outs(), 64'd0);
        repeat (2) tick();
        rstn = 1'b1;
        tick();
        start();
        send_word(32'd1, k);
        body_word(0, 32'h0BAD_C0DE, k);
        dq.push_back(mk_dn(k + 2, 1, 1'b0));
        repeat (4) tick();

        chk("pending_writes", 64'(wq.size()), 64'd0);
        chk("pending_done", 64'(dq.size()), 64'd0);
        chk("pending_accepted", 64'(aq.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/inst_loader.md
Name: inst_loader

Overview:
- Boot-time writer for the instruction memory.
- Takes a byte stream from the UART receiver and assembles 32-bit instructions from it.
- Writes the instructions to consecutive instruction-memory words, starting at word 0.
- Uses the core's order/accepted/done handshake. The controller runs it once before releasing the fetch pipeline.

Parameters:
- LEN_MEMISTR_ADDR, 15, word-address width of the instruction memory. Capacity is 2**LEN_MEMISTR_ADDR words.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rstn  in  1  asynchronous, active-low reset.
- order  in  1  request to start one load.
- accepted  out  1  request taken this cycle.
- done  out  1  one-cycle pulse when the load has finished.
- err  out  1  header word count exceeded capacity. Sticky until the next accepted.
- n_inst  out  LEN_MEMISTR_ADDR+1  number of words written in the current or last load.
- rx_data  in  8  received byte.
- rx_valid  in  1  one-cycle strobe; rx_data is valid in this cycle.
- a_inst_mem  out  LEN_MEMISTR_ADDR  write word address.
- d_inst_mem  out  `LEN_INST  write data.
- we_inst_mem  out  1  write enable, one cycle per word.

Behaviour:
- Clock and reset: one clock, clk. Reset rstn is asynchronous and active-low.
- Reset values: all outputs 0; state IDLE; byte counter 0; word counter 0; shift register 0.
- Reset asserted mid-load aborts the load immediately. No further writes occur, and done is not asserted.
- States: IDLE, HEADER, BODY, FIN.
- Handshake: busy = (state != IDLE); accepted = order & ~busy, combinational.
  - On accepted: state moves to HEADER; err, n_inst and both counters clear.
  - An order seen while busy is ignored.
- Byte intake: rx_valid is honoured only in HEADER and BODY. Bytes arriving in IDLE or FIN are dropped.
- Byte order: bytes are big-endian. The first byte received goes to bits 31:24, using a 2-bit byte counter and a 32-bit shift register.
- HEADER state:
  - Four bytes form N, the instruction count.
  - On the 4th byte, if N > 2**LEN_MEMISTR_ADDR: err <= 1 and state moves to FIN.
  - Otherwise, if N == 0: state moves to FIN.
  - Otherwise: state moves to BODY.
  - N is compared as a full 32-bit value; no truncation before the check.
- BODY state:
  - On the 4th byte of each word, in the following cycle: we_inst_mem = 1, a_inst_mem = word counter, d_inst_mem = assembled word.
  - The word counter and n_inst increment in the same cycle as that write.
  - Write latency is exactly 1 cycle after the 4th rx_valid.
  - After the write of word N-1, state moves to FIN.
  - A new rx_valid coinciding with the write cycle is accepted; the registered write and byte intake are independent.
- FIN state: done = 1 for exactly one cycle, then state returns to IDLE.
  - done therefore follows the last write by 1 cycle.
  - In the error and N == 0 cases, done follows the 4th header byte by 1 cycle.
- Address range: a_inst_mem never exceeds N-1, so there is no wrap-around.
- Data integrity: a partially received word is never written.
- Outputs are held when no write occurs:
  - a_inst_mem and d_inst_mem hold their last value.
  - we_inst_mem is 0 outside write cycles.
- No timeout: a stalled stream leaves the block busy until reset.

Decomposition:
- Shared include (include.vh): `LEN_INST (32) is already present. Add state encodings `LDR_IDLE, `LDR_HEADER, `LDR_BODY, `LDR_FIN (2 bits).
- Register all state with the existing temp_reg primitive (enable, next, q, clk, rstn).
- Sub-module byte_packer (name fixed): 4-byte big-endian assembler.
  - Inputs: rx_data, rx_valid, clear.
  - Outputs: word, word_valid pulse.
  - The same sub-module serves both HEADER and BODY.

Test Plan:
- Normal load: order, then bytes 00 00 00 02 | DE AD BE EF | 01 23 45 67.
  - Required: write (0, DEADBEEF) and write (1, 01234567), each 1 cycle after its 4th byte.
  - done 1 cycle after the second write; n_inst = 2; err = 0.
- Empty program: header 00 00 00 00.
  - Required: no we_inst_mem; done 1 cycle after the 4th byte; n_inst = 0.
- Oversize: LEN_MEMISTR_ADDR = 4, header 00 00 00 11 (17 > 16).
  - Required: err = 1; done 1 cycle after the header; no writes; following bytes ignored.
- Full capacity: LEN_MEMISTR_ADDR = 4, N = 16, words 0..15.
  - Required: addresses 0..15 in order, last address 15; n_inst = 16; done once.
- Handshake: order held high throughout a load.
  - Required: accepted only in the first cycle and again in the cycle after done returns the block to IDLE.
  - Bytes sent before order, with rx_valid pulses while in IDLE, are dropped.
- Reset mid-BODY: drop rstn after 6 body bytes.
  - Required: all outputs 0 asynchronously; no write of the partial word.
  - A fresh load after reset starts at address 0.
